// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cpu_pkg
// Brief   : Shared types and opcode constants for the CPU front end.
// Revision: 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int INSTR_W = 32;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/cpu_next_pc.sv
`default_nettype none
// ============================================================================
// Module  : cpu_next_pc
// Brief   : Combinational next-PC selection: jump, taken branch or PC+4.
// Revision: 1.0 - initial release
// ============================================================================
module cpu_next_pc (
    input  logic [31:0] pc,
    input  logic [25:0] jump_index,
    input  logic        branch_ctrl,
    input  logic        jump_ctrl,
    input  logic        alu_zero,
    input  logic [31:0] branch_offset,
    output logic [31:0] pc_plus4,
    output logic [31:0] next_pc
);

    logic [31:0] w_branch_target;
    logic [31:0] w_jump_target;

    assign pc_plus4        = pc + 32'd4;
    assign w_branch_target = pc_plus4 + (branch_offset << 2);
    assign w_jump_target   = {pc_plus4[31:28], jump_index, 2'b00};

    // Jump outranks branch when the decoder asserts both.
    always_comb begin
        next_pc = pc_plus4;
        if (jump_ctrl) begin
            next_pc = w_jump_target;
        end else if (branch_ctrl && alu_zero) begin
            next_pc = w_branch_target;
        end
    end

endmodule
`default_nettype wire

// File: rtl/cpu_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module  : cpu_instr_fetch
// Brief   : Single-outstanding instruction fetch with response timeout/retry.
// Revision: 1.0 - initial release
// ============================================================================
module cpu_instr_fetch
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [31:0]        imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               imem_rvalid,
    output logic [INSTR_W-1:0] instr_out,
    output logic [5:0]         instruction_opcode,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [31:0]        pc_out,
    output logic [31:0]        pc_plus4_out,
    input  logic               branch_ctrl,
    input  logic               jump_ctrl,
    input  logic               alu_zero,
    input  logic [31:0]        branch_offset,
    output logic               fetch_err
);

    localparam int                 c_CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

    fetch_state_t       r_state;
    fetch_state_t       w_state_next;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_imem_req;
    logic [31:0]        r_imem_addr;
    logic [INSTR_W-1:0] r_instr;
    logic               r_valid;
    logic [31:0]        r_pc;
    logic               r_err;
    logic               w_capture;
    logic               w_timeout;
    logic               w_consume;
    logic [31:0]        w_next_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    w_state_next = FETCH;
            FETCH:   w_state_next = WAIT;
            WAIT: begin
                if (imem_rvalid) begin
                    w_state_next = HOLD;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_state_next = FETCH;
                end
            end
            HOLD: begin
                if (instr_ready) begin
                    w_state_next = FETCH;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        w_capture = 1'b0;
        w_timeout = 1'b0;
        w_consume = 1'b0;
        case (r_state)
            WAIT: begin
                w_capture = imem_rvalid;
                w_timeout = !imem_rvalid && (r_cnt == c_CNT_LAST);
            end
            HOLD:    w_consume = instr_ready;
            default: ;
        endcase
    end

    // The request is registered off the next state so it is high exactly
    // while the FSM sits in FETCH; the address always tracks the PC.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_imem_req  <= 1'b0;
            r_imem_addr <= RESET_PC;
            r_instr     <= '0;
            r_valid     <= 1'b0;
            r_pc        <= RESET_PC;
            r_err       <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_imem_req <= (w_state_next == FETCH);
            if (r_state == FETCH) begin
                r_cnt <= '0;
            end else if (r_state == WAIT && !imem_rvalid) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_capture) begin
                r_instr <= imem_rdata;
                r_valid <= 1'b1;
            end
            if (w_consume) begin
                r_valid     <= 1'b0;
                r_pc        <= w_next_pc;
                r_imem_addr <= w_next_pc;
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    cpu_next_pc u_next_pc (
        .pc            (r_pc),
        .jump_index    (r_instr[25:0]),
        .branch_ctrl   (branch_ctrl),
        .jump_ctrl     (jump_ctrl),
        .alu_zero      (alu_zero),
        .branch_offset (branch_offset),
        .pc_plus4      (pc_plus4_out),
        .next_pc       (w_next_pc)
    );

    assign imem_req           = r_imem_req;
    assign imem_addr          = r_imem_addr;
    assign instr_out          = r_instr;
    assign instruction_opcode = r_instr[31:26];
    assign instr_valid        = r_valid;
    assign pc_out             = r_pc;
    assign fetch_err          = r_err;

endmodule
`default_nettype wire
